// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the instruction fetch sequencer: state encoding,
// PC step and byte/word address helpers.
package fetch_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_HOLD  = 2'd2
   } fetch_state_e;

   localparam logic [31:0] PC_INC = 32'd4;

   function automatic logic [31:0] word_addr(input logic [31:0] byte_pc);
      return {2'b00, byte_pc[31:2]};
   endfunction

   function automatic logic [31:0] align_pc(input logic [31:0] byte_pc);
      return {byte_pc[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus: control inputs, instruction-memory port and decode
// handshake. master = sequencer side, slave = memory/decode/control side.
interface fetch_sequencer_if;
   logic        fetch_en;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;

   modport master (
      input  fetch_en, redirect_valid, redirect_pc, imem_rdata, out_ready,
      output imem_addr, out_valid, out_instr, out_pc
   );

   modport slave (
      output fetch_en, redirect_valid, redirect_pc, imem_rdata, out_ready,
      input  imem_addr, out_valid, out_instr, out_pc
   );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: drives a registered-read instruction memory and
// offers one instruction per cycle to decode, with a one-entry skid for stalls.
//
// state    | meaning
// ST_IDLE  | nothing in flight, out_valid low
// ST_FETCH | imem_rdata is the instruction at cur_pc_q, offered to decode
// ST_HOLD  | stalled instruction parked in hold_instr_q/hold_pc_q, offered
module fetch_sequencer
   import fetch_sequencer_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned IMEM_WORDS = 1024
) (
   input logic               clk,
   input logic               rst_n,
   fetch_sequencer_if.master bus
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  cur_pc_q, cur_pc_d;
   logic [31:0]  hold_instr_q, hold_instr_d;
   logic [31:0]  hold_pc_q, hold_pc_d;
   logic         issue;
   logic [31:0]  issue_pc;
   logic         unused_redirect_lsbs;

   assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         pc_q         <= RESET_PC;
         cur_pc_q     <= RESET_PC;
         hold_instr_q <= '0;
         hold_pc_q    <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         cur_pc_q     <= cur_pc_d;
         hold_instr_q <= hold_instr_d;
         hold_pc_q    <= hold_pc_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      cur_pc_d      = cur_pc_q;
      hold_instr_d  = hold_instr_q;
      hold_pc_d     = hold_pc_q;
      issue         = 1'b0;
      issue_pc      = pc_q;
      bus.out_valid = 1'b0;
      bus.out_instr = '0;
      bus.out_pc    = '0;

      // A redirect squashes whatever is on offer; no handshake this cycle.
      if (bus.redirect_valid) begin
         if (bus.fetch_en) begin
            issue    = 1'b1;
            issue_pc = align_pc(bus.redirect_pc);
         end else begin
            pc_d    = align_pc(bus.redirect_pc);
            state_d = ST_IDLE;
         end
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               issue = bus.fetch_en;
            end
            ST_FETCH: begin
               bus.out_valid = 1'b1;
               bus.out_instr = bus.imem_rdata;
               bus.out_pc    = cur_pc_q;
               if (bus.out_ready) begin
                  if (bus.fetch_en) issue = 1'b1;
                  else              state_d = ST_IDLE;
               end else begin
                  hold_instr_d = bus.imem_rdata;
                  hold_pc_d    = cur_pc_q;
                  state_d      = ST_HOLD;
               end
            end
            ST_HOLD: begin
               bus.out_valid = 1'b1;
               bus.out_instr = hold_instr_q;
               bus.out_pc    = hold_pc_q;
               if (bus.out_ready) begin
                  if (bus.fetch_en) issue = 1'b1;
                  else              state_d = ST_IDLE;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      if (issue) begin
         cur_pc_d = issue_pc;
         pc_d     = issue_pc + PC_INC;
         state_d  = ST_FETCH;
      end

      // When idle or stalled the memory still sees pc_q; that read is discarded.
      bus.imem_addr = issue ? word_addr(issue_pc) : word_addr(pc_q);
   end

   a_imem_depth_pow2: assert property (@(posedge clk)
      (IMEM_WORDS != 0) && ((IMEM_WORDS & (IMEM_WORDS - 1)) == 0));

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus random traffic, checked by
// a stream scoreboard fed from a PC-sequence reference model.
module tb_fetch_sequencer;

   localparam logic [31:0] RESET_PC   = 32'h0000_0000;
   localparam int unsigned IMEM_WORDS = 1024;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } item_t;

   logic clk = 1'b0;
   logic rst_n;

   fetch_sequencer_if bus();

   fetch_sequencer #(.RESET_PC(RESET_PC), .IMEM_WORDS(IMEM_WORDS)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   logic [31:0] mem [IMEM_WORDS];

   function automatic logic [31:0] mem_word(input logic [31:0] waddr);
      return mem[waddr % IMEM_WORDS];
   endfunction

   always @(posedge clk) bus.imem_rdata <= mem_word(bus.imem_addr);

   int n_checks = 0;
   int n_fail   = 0;
   int n_hs     = 0;

   item_t       exp_q[$];
   logic [31:0] model_pc;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
      end
   endtask

   // Accepted instructions always form a sequential PC stream that restarts
   // at the redirect target or at RESET_PC.
   task automatic refill();
      item_t it;
      while (exp_q.size() < 8) begin
         it.pc    = model_pc;
         it.instr = mem_word(model_pc >> 2);
         exp_q.push_back(it);
         model_pc = model_pc + 32'd4;
      end
   endtask

   task automatic model_restart(input logic [31:0] pc);
      exp_q.delete();
      model_pc = {pc[31:2], 2'b00};
      refill();
   endtask

   task automatic drive(input logic rst, input logic fe, input logic rdy,
                        input logic rv, input logic [31:0] rpc);
      @(posedge clk);
      #1;
      rst_n              = rst;
      bus.fetch_en       = fe;
      bus.out_ready      = rdy;
      bus.redirect_valid = rv & rst;
      bus.redirect_pc    = rpc;
      if (!rst)    model_restart(RESET_PC);
      else if (rv) model_restart(rpc);
      else         refill();
      @(negedge clk);
   endtask

   logic        prev_stall = 1'b0;
   logic [31:0] prev_pc, prev_instr;

   always @(negedge clk) begin
      item_t it;
      if (!rst_n) begin
         chk("reset_out_valid", bus.out_valid, 0);
         prev_stall = 1'b0;
      end else begin
         if (prev_stall && !bus.redirect_valid) begin
            chk("stall_valid", bus.out_valid, 1);
            chk("stall_pc", bus.out_pc, prev_pc);
            chk("stall_instr", bus.out_instr, prev_instr);
         end
         if (bus.redirect_valid) chk("redirect_out_valid", bus.out_valid, 0);
         if (bus.out_valid && bus.out_ready) begin
            n_hs++;
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL scoreboard_empty: got pc %h, nothing expected", bus.out_pc);
            end else begin
               it = exp_q.pop_front();
               chk("sb_pc", bus.out_pc, it.pc);
               chk("sb_instr", bus.out_instr, it.instr);
            end
         end
         prev_stall = bus.out_valid && !bus.out_ready;
         prev_pc    = bus.out_pc;
         prev_instr = bus.out_instr;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int hs_start;
      for (int i = 0; i < IMEM_WORDS; i++) mem[i] = 32'h1000_0000 + i;
      rst_n              = 1'b0;
      bus.fetch_en       = 1'b0;
      bus.out_ready      = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      model_restart(RESET_PC);
      repeat (3) @(negedge clk);
      chk("rst_valid", bus.out_valid, 0);
      chk("rst_addr", bus.imem_addr, RESET_PC >> 2);

      drive(1, 0, 0, 0, 0);
      chk("idle_no_fetch_valid", bus.out_valid, 0);

      // sequential stream from reset
      drive(1, 1, 1, 0, 0);
      chk("first_issue_addr", bus.imem_addr, 0);
      chk("first_issue_valid", bus.out_valid, 0);
      drive(1, 1, 1, 0, 0);
      chk("seq0_valid", bus.out_valid, 1);
      chk("seq0_pc", bus.out_pc, 0);
      chk("seq0_addr", bus.imem_addr, 1);
      drive(1, 1, 1, 0, 0);
      chk("seq1_pc", bus.out_pc, 4);
      chk("seq1_addr", bus.imem_addr, 2);

      // three-cycle stall on PC 8
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, 0, 0, 0);
         chk("stall8_valid", bus.out_valid, 1);
         chk("stall8_pc", bus.out_pc, 8);
         chk("stall8_instr", bus.out_instr, 32'h1000_0002);
         chk("stall8_addr", bus.imem_addr, 3);
      end
      drive(1, 1, 1, 0, 0);
      chk("release8_pc", bus.out_pc, 8);
      drive(1, 1, 1, 0, 0);
      chk("after_stall_pc", bus.out_pc, 12);
      chk("after_stall_instr", bus.out_instr, 32'h1000_0003);

      // redirect while holding
      drive(1, 1, 0, 0, 0);
      drive(1, 1, 0, 0, 0);
      chk("hold16_pc", bus.out_pc, 16);
      drive(1, 1, 0, 1, 32'h0000_0103);
      chk("redir_hold_valid", bus.out_valid, 0);
      chk("redir_hold_addr", bus.imem_addr, 32'h40);
      drive(1, 1, 1, 0, 0);
      chk("redir_pc", bus.out_pc, 32'h100);
      chk("redir_instr", bus.out_instr, 32'h1000_0040);

      // wrap at the top of the address space
      drive(1, 1, 1, 1, 32'hFFFF_FFFC);
      chk("wrap_redir_addr", bus.imem_addr, 32'h3FFF_FFFF);
      drive(1, 1, 1, 0, 0);
      chk("wrap_top_pc", bus.out_pc, 32'hFFFF_FFFC);
      chk("wrap_next_addr", bus.imem_addr, 0);
      drive(1, 1, 1, 0, 0);
      chk("wrap_zero_pc", bus.out_pc, 0);

      // drop fetch_en while PC 16 is on offer
      repeat (3) drive(1, 1, 1, 0, 0);
      drive(1, 0, 1, 0, 0);
      chk("drop_en_valid", bus.out_valid, 1);
      chk("drop_en_pc", bus.out_pc, 16);
      drive(1, 0, 1, 0, 0);
      chk("disabled_valid", bus.out_valid, 0);
      drive(1, 0, 1, 0, 0);
      chk("disabled_addr", bus.imem_addr, 5);
      drive(1, 1, 1, 0, 0);
      chk("reenable_addr", bus.imem_addr, 5);
      drive(1, 1, 1, 0, 0);
      chk("reenable_pc", bus.out_pc, 20);

      // reset pulse while holding
      drive(1, 1, 0, 0, 0);
      drive(1, 1, 0, 0, 0);
      chk("pre_reset_hold_pc", bus.out_pc, 24);
      drive(0, 1, 0, 0, 0);
      chk("reset_in_hold_valid", bus.out_valid, 0);
      drive(1, 1, 1, 0, 0);
      chk("restart_addr", bus.imem_addr, RESET_PC >> 2);
      drive(1, 1, 1, 0, 0);
      chk("restart_pc", bus.out_pc, RESET_PC);

      // random traffic
      hs_start = n_hs;
      for (int i = 0; i < 600; i++) begin
         logic        r, fe, rdy, rv;
         logic [31:0] rpc;
         r   = ($urandom_range(0, 99) != 0);
         fe  = ($urandom_range(0, 3) != 0);
         rdy = ($urandom_range(0, 2) != 0);
         rv  = ($urandom_range(0, 15) == 0);
         rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                           : 32'($urandom);
         drive(r, fe, rdy, rv, rpc);
      end
      n_checks++;
      if (n_hs - hs_start < 100) begin
         n_fail++;
         $display("FAIL random_handshakes: got %0d required at least 100", n_hs - hs_start);
      end

      // full throughput once traffic settles
      repeat (3) drive(1, 1, 1, 0, 0);
      for (int i = 0; i < 4; i++) begin
         drive(1, 1, 1, 0, 0);
         chk("steady_valid", bus.out_valid, 1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
